// File: rtl/fab_wb_arbiter.sv
// fab_wb_arbiter: merges the two FAB slot results onto the single regfile
// write port. Writes leave in program order. The older live slot bypasses
// straight to the port when nothing is queued. Everything else waits in a
// small circular queue, and back-pressure is asserted while the queue is full.

// Per-slot decode: a slot result is live only when sampled, written, valid
// and not targeting r0.
module fab_wb_slot_dec (
  input  logic [38:0] rfw,
  input  logic        en,
  output logic        live,
  output logic [4:0]  addr,
  output logic [31:0] data
);
  assign live = en & rfw[38] & rfw[37] & (rfw[36:32] != 5'd0);
  assign addr = rfw[36:32];
  assign data = rfw[31:0];
endmodule

module fab_wb_arbiter #(
  parameter int DEPTH = 2  // write-queue entries, 2..8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [38:0]                rfw_a,
  input  logic                       num_a,
  input  logic [38:0]                rfw_b,
  input  logic                       num_b,
  output logic                       wb_we,
  output logic [4:0]                 wb_addr,
  output logic [31:0]                wb_data,
  output logic                       stop,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic [15:0]                stall_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int NUM_SLOTS = 2;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_ent_t;

  // Pointer increment that wraps at DEPTH. DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Queue state
  wb_ent_t       mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr1;
  logic [OW-1:0] occ_q, occ_nxt;
  logic          full, empty, sample;

  // Slot decode
  logic [NUM_SLOTS-1:0][38:0] slot_rfw;
  logic [NUM_SLOTS-1:0]       slot_live;
  logic [NUM_SLOTS-1:0][4:0]  slot_addr;
  logic [NUM_SLOTS-1:0][31:0] slot_data;

  // Program-order view of the slots
  logic    a_older;
  logic    old_live, yng_live;
  wb_ent_t old_ent, yng_ent;

  // Per-cycle grant / queue control
  logic    grant, pop;
  wb_ent_t gnt_ent;
  logic [1:0] enq_n;
  wb_ent_t enq_e0, enq_e1;

  assign full  = (occ_q == OW'(DEPTH));
  assign empty = (occ_q == '0);
  // While full, the slot registers hold repeats, so their contents are ignored.
  // The reset cycle is also ignored.
  assign sample = ~full & ~rst;

  assign slot_rfw = {rfw_b, rfw_a};

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    fab_wb_slot_dec u_dec (
      .rfw  (slot_rfw[i]),
      .en   (sample),
      .live (slot_live[i]),
      .addr (slot_addr[i]),
      .data (slot_data[i])
    );
  end

  // Tag 0 is older. On equal tags, slot A wins.
  assign a_older  = (num_a == num_b) | ~num_a;
  assign old_live = a_older ? slot_live[0] : slot_live[1];
  assign yng_live = a_older ? slot_live[1] : slot_live[0];
  assign old_ent  = a_older ? wb_ent_t'{slot_addr[0], slot_data[0]}
                            : wb_ent_t'{slot_addr[1], slot_data[1]};
  assign yng_ent  = a_older ? wb_ent_t'{slot_addr[1], slot_data[1]}
                            : wb_ent_t'{slot_addr[0], slot_data[0]};

  assign wr_ptr1 = ptr_inc(wr_ptr);

  // Grant selection: queue head, then older live slot, then younger live slot.
  // Anything not granted this cycle is queued in program order.
  always_comb begin
    grant   = 1'b0;
    pop     = 1'b0;
    gnt_ent = '0;
    enq_n   = 2'd0;
    enq_e0  = yng_ent;
    enq_e1  = yng_ent;
    if (!empty) begin
      grant   = 1'b1;
      pop     = 1'b1;
      gnt_ent = mem[rd_ptr];
      enq_n   = {1'b0, old_live} + {1'b0, yng_live};
      enq_e0  = old_live ? old_ent : yng_ent;
    end else if (old_live) begin
      grant   = 1'b1;
      gnt_ent = old_ent;
      enq_n   = {1'b0, yng_live};
    end else if (yng_live) begin
      grant   = 1'b1;
      gnt_ent = yng_ent;
    end
  end

  // Net change is at most +1 per sampled cycle, so occupancy stays <= DEPTH.
  assign occ_nxt = occ_q + OW'(enq_n) - OW'(pop);

  // Queue storage writes. The data holds no state that needs resetting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (enq_n != 2'd0) mem[wr_ptr]  <= enq_e0;
      if (enq_n == 2'd2) mem[wr_ptr1] <= enq_e1;
    end
  end

  // Pointer and occupancy update. Reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case (enq_n)
        2'd1:    wr_ptr <= wr_ptr1;
        2'd2:    wr_ptr <= ptr_inc(wr_ptr1);
        default: wr_ptr <= wr_ptr;
      endcase
      occ_q <= occ_nxt;
    end
  end

  // Saturating count of back-pressure cycles
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (full && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  // The port stays quiet while reset is clearing the queue.
  assign wb_we   = grant & ~rst;
  assign wb_addr = wb_we ? gnt_ent.addr : 5'd0;
  assign wb_data = wb_we ? gnt_ent.data : 32'd0;
  assign stop    = full;
  assign occ     = occ_q;

endmodule
